ram_test_seq: RTL

Control sequencer that sits directly upstream of the RAM test datapath. It drives the address counter strobes (clr, count), the RAM write/read enables, the data-bus buffer enable and the error-register sample strobe. Each pass writes the whole RAM, then reads it back and checks it. The error count is cleared once per run, so errors accumulate across passes.

---
 rtl/ram_test_pkg.sv | 8 +
 rtl/ram_seq_timer.sv | 19 +
 rtl/ram_test_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/ram_test_pkg.sv
// ram_test_pkg: shared state encoding and widths for the RAM test sequencer
package ram_test_pkg;
    localparam int TMR_W = 4;
    localparam int PASS_W = 8;
    typedef enum logic [3:0] {
        IDLE, CLEAR, WR_PULSE, WR_NEXT, RD_ACC, RD_CHK, RD_NEXT, DONE, HOLD
    } state_t;
endpackage

// File: rtl/ram_seq_timer.sv
// ram_seq_timer: loadable down-counter with zero flag that stops at zero instead of wrapping
module ram_seq_timer
    import ram_test_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);
    logic [TMR_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/ram_test_seq.sv
// ram_test_seq: write-all/read-all RAM test sequencer; optional single-step mode via RAM_SEQ_STEP_EN
module ram_test_seq
    import ram_test_pkg::*;
#(
    parameter int WR_CYC  = 2,
    parameter int RD_WAIT = 2,
    parameter int PASSES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
`ifdef RAM_SEQ_STEP_EN
    input  logic              step,
    input  logic              step_mode,
`endif
    input  logic              adr_limit,
    output logic              clr,
    output logic              count,
    output logic              all_clear,
    output logic              ram_we_n,
    output logic              ram_oe_n,
    output logic              OE_buffer,
    output logic              wr_err_reg_clock,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_cnt
);
    state_t st, nxt;
    logic tmr_zero, tmr_load, hold_on, step_go, hold_rd, at_next;
`ifdef RAM_SEQ_STEP_EN
    assign hold_on = step_mode;
    assign step_go = step;
    // remembers which phase parked in HOLD so the release resumes the right decision
    always_ff @(posedge clk) begin
        if (rst) hold_rd <= 1'b0;
        else if (nxt == HOLD && st != HOLD) hold_rd <= st == RD_CHK;
    end
`else
    assign hold_on = 1'b0;
    assign step_go = 1'b0;
    assign hold_rd = 1'b0;
`endif
    always_comb begin
        nxt = st;
        case (st)
            IDLE:     nxt = start ? CLEAR : IDLE;
            CLEAR:    nxt = WR_PULSE;
            WR_PULSE: nxt = tmr_zero ? (hold_on ? HOLD : WR_NEXT) : WR_PULSE;
            WR_NEXT:  nxt = adr_limit ? RD_ACC : WR_PULSE;
            RD_ACC:   nxt = tmr_zero ? RD_CHK : RD_ACC;
            RD_CHK:   nxt = hold_on ? HOLD : RD_NEXT;
            RD_NEXT:  nxt = !adr_limit ? RD_ACC : (pass_cnt < PASS_W'(PASSES) ? WR_PULSE : DONE);
            DONE:     nxt = IDLE;
            HOLD:     nxt = step_go ? (hold_rd ? RD_NEXT : WR_NEXT) : HOLD;
        endcase
        if (abort) nxt = IDLE;
    end
    assign tmr_load = (nxt == WR_PULSE && st != WR_PULSE) || (nxt == RD_ACC && st != RD_ACC);
    assign at_next = nxt == WR_NEXT || nxt == RD_NEXT;
    ram_seq_timer u_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (st == WR_PULSE || st == RD_ACC),
        .load_val (nxt == WR_PULSE ? TMR_W'(WR_CYC - 1) : TMR_W'(RD_WAIT - 1)),
        .zero     (tmr_zero)
    );
    // outputs decode the next state so each strobe lines up with its own state
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            clr <= 1'b0;
            count <= 1'b0;
            all_clear <= 1'b0;
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            OE_buffer <= 1'b0;
            wr_err_reg_clock <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass_cnt <= '0;
        end else begin
            st <= nxt;
            clr <= nxt == CLEAR || (at_next && adr_limit);
            count <= at_next && !adr_limit;
            all_clear <= nxt == CLEAR;
            ram_we_n <= nxt != WR_PULSE;
            ram_oe_n <= !(nxt == RD_ACC || nxt == RD_CHK);
            OE_buffer <= nxt == WR_PULSE || nxt == WR_NEXT;
            wr_err_reg_clock <= nxt == RD_CHK;
            busy <= nxt != IDLE;
            done <= nxt == DONE;
            pass_cnt <= nxt == CLEAR ? '0 :
                        (nxt == RD_NEXT && adr_limit && pass_cnt != '1) ? pass_cnt + 1'b1 : pass_cnt;
        end
    end
endmodule
